// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - HH:MM:SS BCD real-time clock core with time-set FSM and 12h/24h output
// Alarm ports and logic are present only when TIME_KEEPER_ALARM_EN is defined.
module time_keeper #(
  parameter int DIV_CONST = 50_000_000,
  parameter int DIV_WIDTH = 26,
  parameter int START_HR  = 23,
  parameter int START_MIN = 45,
  parameter int START_SEC = 11
) (
  input  logic        i_clk,
  input  logic        i_srst,
  input  logic        i_mode_12h,
  input  logic        i_set_btn,
  input  logic        i_inc_btn,
`ifdef TIME_KEEPER_ALARM_EN
  input  logic [7:0]  i_alarm_hr,
  input  logic [7:0]  i_alarm_min,
  input  logic        i_alarm_arm,
  output logic        o_alarm,
`endif
  output logic [23:0] o_time,
  output logic        o_pm,
  output logic        o_tick_1hz,
  output logic [1:0]  o_set_field
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_CONST - 1);
  localparam logic [3:0] START_H1 = 4'(START_HR / 10);
  localparam logic [3:0] START_H0 = 4'(START_HR % 10);
  localparam logic [3:0] START_M1 = 4'(START_MIN / 10);
  localparam logic [3:0] START_M0 = 4'(START_MIN % 10);
  localparam logic [3:0] START_S1 = 4'(START_SEC / 10);
  localparam logic [3:0] START_S0 = 4'(START_SEC % 10);

  state_e                 state_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [3:0]             s0_q, s1_q, m0_q, m1_q, h0_q, h1_q;
  logic [3:0]             s0_d, s1_d, m0_d, m1_d, h0_d, h1_d;
  logic                   tick;
  logic [7:0]             hr_disp;
  logic                   pm;

  function automatic logic [7:0] hr_inc(input logic [3:0] h1, input logic [3:0] h0);
    if (h1 == 4'd2 && h0 == 4'd3) return 8'h00;
    else if (h0 == 4'd9)          return {h1 + 4'd1, 4'd0};
    else                          return {h1, h0 + 4'd1};
  endfunction

  // Minutes wrap 59 -> 00 on their own; the caller decides whether that carries into hours.
  function automatic logic [7:0] min_inc(input logic [3:0] m1, input logic [3:0] m0);
    if (m0 != 4'd9)      return {m1, m0 + 4'd1};
    else if (m1 == 4'd5) return 8'h00;
    else                 return {m1 + 4'd1, 4'd0};
  endfunction

  assign tick = (state_q == RUN) && (div_q == DIV_LAST);

  // Full one-second advance with the whole carry chain resolved in one cycle.
  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    m0_d = m0_q;
    m1_d = m1_q;
    h0_d = h0_q;
    h1_d = h1_q;
    if (s0_q != 4'd9) begin
      s0_d = s0_q + 4'd1;
    end else begin
      s0_d = 4'd0;
      if (s1_q != 4'd5) begin
        s1_d = s1_q + 4'd1;
      end else begin
        s1_d = 4'd0;
        {m1_d, m0_d} = min_inc(m1_q, m0_q);
        if (m1_q == 4'd5 && m0_q == 4'd9) {h1_d, h0_d} = hr_inc(h1_q, h0_q);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q <= RUN;
      div_q   <= '0;
      h1_q    <= START_H1;
      h0_q    <= START_H0;
      m1_q    <= START_M1;
      m0_q    <= START_M0;
      s1_q    <= START_S1;
      s0_q    <= START_S0;
    end else begin
      case (state_q)
        RUN: begin
          if (i_set_btn) begin
            state_q <= SET_HR;
            div_q   <= '0;
            s1_q    <= 4'd0;
            s0_q    <= 4'd0;
          end else if (tick) begin
            div_q <= '0;
            h1_q  <= h1_d;
            h0_q  <= h0_d;
            m1_q  <= m1_d;
            m0_q  <= m0_d;
            s1_q  <= s1_d;
            s0_q  <= s0_d;
          end else begin
            div_q <= div_q + DIV_WIDTH'(1);
          end
        end
        SET_HR: begin
          if (i_set_btn)      state_q <= SET_MIN;
          else if (i_inc_btn) {h1_q, h0_q} <= hr_inc(h1_q, h0_q);
        end
        SET_MIN: begin
          if (i_set_btn) begin
            state_q <= RUN;
            div_q   <= '0;
          end else if (i_inc_btn) begin
            {m1_q, m0_q} <= min_inc(m1_q, m0_q);
          end
        end
        default: begin
          state_q <= RUN;
          div_q   <= '0;
        end
      endcase
    end
  end

`ifdef TIME_KEEPER_ALARM_EN
  logic alarm_q;

  // Fires only on a tick that lands exactly on HH:MM:00; any button acknowledges it.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      alarm_q <= 1'b0;
    end else if (!i_alarm_arm || i_set_btn || i_inc_btn) begin
      alarm_q <= 1'b0;
    end else if (tick && {h1_d, h0_d} == i_alarm_hr && {m1_d, m0_d} == i_alarm_min &&
                 s1_d == 4'd0 && s0_d == 4'd0) begin
      alarm_q <= 1'b1;
    end
  end

  assign o_alarm = alarm_q;
`endif

  // 12h view: 00 -> 12 AM, 13..23 -> 01..11 PM, done digit-wise on the BCD hour.
  always_comb begin
    hr_disp = {h1_q, h0_q};
    pm      = 1'b0;
    if (i_mode_12h) begin
      pm = (h1_q == 4'd2) || (h1_q == 4'd1 && h0_q >= 4'd2);
      if (h1_q == 4'd0 && h0_q == 4'd0)      hr_disp = 8'h12;
      else if (h1_q == 4'd1 && h0_q >= 4'd3) hr_disp = {4'd0, h0_q - 4'd2};
      else if (h1_q == 4'd2 && h0_q <= 4'd1) hr_disp = {4'd0, h0_q + 4'd8};
      else if (h1_q == 4'd2)                 hr_disp = {4'd1, h0_q - 4'd2};
    end
  end

  assign o_time      = {hr_disp, m1_q, m0_q, s1_q, s0_q};
  assign o_pm        = pm;
  assign o_tick_1hz  = tick;
  assign o_set_field = state_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - self-checking bench for time_keeper with DIV_CONST=4
// Integer time model feeds a scoreboard queue; directed checks cover the key boundaries.
module tb_time_keeper;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        mode_12h = 1'b0;
  logic        set_btn = 1'b0;
  logic        inc_btn = 1'b0;
  logic [23:0] o_time;
  logic        o_pm;
  logic        o_tick;
  logic [1:0]  o_field;
  logic [7:0]  alarm_hr = 8'h00;
  logic [7:0]  alarm_min = 8'h01;
  logic        alarm_arm = 1'b0;
  logic        o_alarm;

  always #5 clk = ~clk;

  time_keeper #(
    .DIV_CONST(4),
    .DIV_WIDTH(3),
    .START_HR (23),
    .START_MIN(45),
    .START_SEC(11)
  ) dut (
    .i_clk      (clk),
    .i_srst     (srst),
    .i_mode_12h (mode_12h),
    .i_set_btn  (set_btn),
    .i_inc_btn  (inc_btn),
`ifdef TIME_KEEPER_ALARM_EN
    .i_alarm_hr (alarm_hr),
    .i_alarm_min(alarm_min),
    .i_alarm_arm(alarm_arm),
    .o_alarm    (o_alarm),
`endif
    .o_time     (o_time),
    .o_pm       (o_pm),
    .o_tick_1hz (o_tick),
    .o_set_field(o_field)
  );

`ifndef TIME_KEEPER_ALARM_EN
  assign o_alarm = 1'b0;
`endif

  typedef struct {
    logic [23:0] t;
    logic        pm;
    logic        tick;
    logic [1:0]  fld;
    logic        alarm;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   mh, mm, msec, mst, mdiv;
  int   a_h = 0;
  int   a_m = 1;
  bit   malarm;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    int   hd;
    hd = mh;
    if (mode_12h) hd = (mh % 12 == 0) ? 12 : mh % 12;
    e.t     = {bcd(hd), bcd(mm), bcd(msec)};
    e.pm    = mode_12h && (mh >= 12);
    e.tick  = (mst == 0) && (mdiv == 3);
    e.fld   = 2'(mst);
    e.alarm = malarm;
    sb_q.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_sb: observed empty queue expected one entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_time"}, o_time, e.t);
    chk({tag, "_pm"}, o_pm, e.pm);
    chk({tag, "_tick"}, o_tick, e.tick);
    chk({tag, "_field"}, o_field, e.fld);
`ifdef TIME_KEEPER_ALARM_EN
    chk({tag, "_alarm"}, o_alarm, e.alarm);
`endif
  endtask

  // One clock with the given button/reset pulses; the model predicts the post-edge state.
  task automatic clk1(input bit set, input bit inc, input bit rst, input string tag);
    bit tick_now;
    bit clr;
    srst    = rst;
    set_btn = set;
    inc_btn = inc;
    if (rst) begin
      mh = 23; mm = 45; msec = 11; mst = 0; mdiv = 0; malarm = 0;
    end else begin
      tick_now = (mst == 0) && (mdiv == 3) && !set;
      clr      = set || inc || !alarm_arm;
      if (set) begin
        case (mst)
          0:       begin mst = 1; msec = 0; mdiv = 0; end
          1:       mst = 2;
          default: begin mst = 0; mdiv = 0; end
        endcase
      end else if (mst == 0) begin
        if (mdiv == 3) begin
          mdiv = 0;
          msec++;
          if (msec == 60) begin msec = 0; mm++; end
          if (mm == 60) begin mm = 0; mh++; end
          if (mh == 24) mh = 0;
        end else begin
          mdiv++;
        end
      end else if (inc) begin
        if (mst == 1) mh = (mh + 1) % 24;
        else          mm = (mm + 1) % 60;
      end
      if (clr) malarm = 0;
      else if (tick_now && mh == a_h && mm == a_m && msec == 0) malarm = 1;
    end
    push_exp();
    @(posedge clk);
    #1;
    srst    = 1'b0;
    set_btn = 1'b0;
    inc_btn = 1'b0;
    check_sb(tag);
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) clk1(0, 0, 0, tag);
  endtask

  initial begin
    clk1(0, 0, 1, "reset");
    chk("rst_time", o_time, 24'h234511);
    chk("rst_field", o_field, 2'b00);
    chk("rst_tick", o_tick, 1'b0);
    run_n(3, "t1_run");
    chk("t1_tick_4th_cycle", o_tick, 1'b1);
    chk("t1_time_before_tick", o_time, 24'h234511);
    clk1(0, 0, 0, "t1_tick");
    chk("t1_after_tick", o_time, 24'h234512);

    clk1(1, 0, 0, "t2_set_hr");
    chk("t2_field_hr", o_field, 2'b01);
    chk("t2_sec_zero", o_time[7:0], 8'h00);
    clk1(1, 0, 0, "t2_set_min");
    chk("t2_field_min", o_field, 2'b10);
    repeat (14) clk1(0, 1, 0, "t2_inc_min");
    clk1(1, 0, 0, "t2_to_run");
    chk("t2_preload", o_time, 24'h235900);
    run_n(236, "t2_run");
    chk("t2_235959", o_time, 24'h235959);
    run_n(4, "t2_wrap");
    chk("t2_midnight", o_time, 24'h000000);

    clk1(1, 0, 0, "t3_set_hr");
    repeat (22) clk1(0, 1, 0, "t3_inc_hr");
    chk("t3_hr22", o_time[23:16], 8'h22);
    repeat (3) clk1(0, 1, 0, "t3_inc_hr_wrap");
    chk("t3_hr01", o_time[23:16], 8'h01);
    clk1(1, 0, 0, "t3_set_min");
    repeat (59) clk1(0, 1, 0, "t3_inc_min");
    chk("t3_min59", o_time[15:8], 8'h59);
    clk1(0, 1, 0, "t3_min_wrap");
    chk("t3_min_wrap_no_carry", o_time, 24'h010000);
    clk1(1, 0, 0, "t3_to_run");
    chk("t3_field_run", o_field, 2'b00);
    run_n(3, "t3_restart");
    chk("t3_first_tick", o_tick, 1'b1);
    clk1(0, 0, 0, "t3_first_sec");
    chk("t3_first_sec", o_time, 24'h010001);

    clk1(1, 1, 0, "t4_set_inc");
    chk("t4_field_hr", o_field, 2'b01);
    chk("t4_hr_unchanged", o_time[23:16], 8'h01);
    clk1(1, 0, 0, "t4_set_min");
    clk1(1, 0, 0, "t4_to_run");
    clk1(0, 1, 0, "t4_inc_in_run");
    chk("t4_inc_ignored", o_time, 24'h010000);

    clk1(1, 0, 0, "t5_set_hr");
    repeat (23) clk1(0, 1, 0, "t5_inc_hr");
    mode_12h = 1'b1;
    clk1(0, 0, 0, "t5_mode12");
    chk("t5_h00_disp", o_time[23:16], 8'h12);
    chk("t5_h00_pm", o_pm, 1'b0);
    repeat (12) clk1(0, 1, 0, "t5_inc_to12");
    chk("t5_h12_disp", o_time[23:16], 8'h12);
    chk("t5_h12_pm", o_pm, 1'b1);
    clk1(0, 1, 0, "t5_inc_to13");
    chk("t5_h13_disp", o_time[23:16], 8'h01);
    chk("t5_h13_pm", o_pm, 1'b1);
    mode_12h = 1'b0;
    clk1(0, 0, 0, "t5_mode24");
    chk("t5_h13_24h", o_time[23:16], 8'h13);
    chk("t5_h13_pm24", o_pm, 1'b0);

    clk1(1, 0, 0, "t6_set_min");
    chk("t6_field_min", o_field, 2'b10);
    clk1(0, 1, 1, "t6_reset");
    chk("t6_reset_time", o_time, 24'h234511);
    chk("t6_reset_field", o_field, 2'b00);

`ifdef TIME_KEEPER_ALARM_EN
    alarm_hr  = 8'h00;
    alarm_min = 8'h01;
    a_h       = 0;
    a_m       = 1;
    alarm_arm = 1'b1;
    clk1(1, 0, 0, "t7_set_hr");
    clk1(0, 1, 0, "t7_inc_hr");
    clk1(1, 0, 0, "t7_set_min");
    repeat (15) clk1(0, 1, 0, "t7_inc_min");
    clk1(1, 0, 0, "t7_to_run");
    run_n(232, "t7_run");
    chk("t7_at_0058", o_time, 24'h000058);
    chk("t7_alarm_idle", o_alarm, 1'b0);
    run_n(8, "t7_run_to_alarm");
    chk("t7_at_0100", o_time, 24'h000100);
    chk("t7_alarm_set", o_alarm, 1'b1);
    run_n(4, "t7_hold");
    chk("t7_alarm_hold", o_alarm, 1'b1);
    alarm_arm = 1'b0;
    clk1(0, 0, 0, "t7_disarm");
    chk("t7_alarm_cleared", o_alarm, 1'b0);
    alarm_arm = 1'b1;
    clk1(1, 0, 0, "t7_set_hr2");
    clk1(1, 0, 0, "t7_set_min2");
    clk1(0, 0, 1, "t7_reset");
    chk("t7_reset_time", o_time, 24'h234511);
    chk("t7_reset_alarm", o_alarm, 1'b0);
    chk("t7_reset_field", o_field, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
